sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/sram_arbiter.sv | 29 ++
 rtl/sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// Imported by the arbiter and the controller top.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WHOLD = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int MIN_WAIT_CYCLES = 1;
  localparam int MIN_NUM_PORTS   = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Fixed-priority requester arbiter: highest asserted index wins.
// Produces a one-hot grant and the matching encoded index.
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Multi-port asynchronous SRAM controller with registered pins.
// One access at a time; strobes are computed from the next state.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int NUM_PORTS   = 2,
  parameter int WAIT_CYCLES = 2,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                        clk_50M,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   be,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  inout  wire  [DATA_W-1:0]           ram_data,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [BE_W-1:0]             ram_be_n,
  output logic                        ram_ce_n,
  output logic                        ram_oe_n,
  output logic                        ram_we_n,
  output logic                        busy
);

  localparam int WC    = (WAIT_CYCLES < MIN_WAIT_CYCLES) ?
                         MIN_WAIT_CYCLES : WAIT_CYCLES;
  localparam int CNT_W = $clog2(WC + 1);
  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WC - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   gnt, gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic [IDX_W-1:0]       idx;
  logic                   gnt_v;
  logic                   we_sel;
  logic [ADDR_W-1:0]      addr_sel, addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_sel, dout_q, dout_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [BE_W-1:0]        be_sel, be_n_q, be_n_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   drive_q, drive_d;

  sram_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req_i   (req),
    .gnt_o   (gnt),
    .idx_o   (idx),
    .valid_o (gnt_v)
  );

  assign we_sel    = we[idx];
  assign addr_sel  = addr[int'(idx)*ADDR_W +: ADDR_W];
  assign wdata_sel = wdata[int'(idx)*DATA_W +: DATA_W];
  assign be_sel    = be[int'(idx)*BE_W +: BE_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_v) begin
          state_d = we_sel ? WRITE : READ;
          cnt_d   = '0;
        end
      end
      READ, WRITE: begin
        if (cnt_q == LAST) begin
          state_d = (state_q == READ) ? DONE : WHOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WHOLD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are registered, so they follow the state being entered.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drive_d = 1'b0;
    be_n_d  = '1;
    ack_d   = '0;
    addr_d  = addr_q;
    dout_d  = dout_q;
    gnt_d   = gnt_q;
    unique case (state_d)
      READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      WRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        drive_d = 1'b1;
        be_n_d  = (state_q == IDLE) ? ~be_sel : be_n_q;
      end
      WHOLD: begin
        ce_n_d  = 1'b0;
        drive_d = 1'b1;
        be_n_d  = be_n_q;
      end
      DONE:    ack_d = gnt_q;
      default: ;
    endcase
    if (state_q == IDLE && gnt_v) begin
      addr_d = addr_sel;
      dout_d = wdata_sel;
      gnt_d  = gnt;
    end
  end

  assign rdata_d = (state_q == READ && cnt_q == LAST) ?
                   ram_data : rdata_q;

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      be_n_q  <= '1;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
    end
  end

  assign ram_data = drive_q ? dout_q : {DATA_W{1'bz}};
  assign ram_addr = addr_q;
  assign ram_be_n = be_n_q;
  assign ram_ce_n = ce_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM on the bus.
// Extra 3-port instances cover WAIT_CYCLES of 1 and 4.
module tb_sram_ctrl;

  logic        clk_50M = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [39:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  be = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  wire  [31:0] ram_data;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n, busy;

  logic [2:0]  req_b = '0, req_c = '0;
  logic [2:0]  ack_b, ack_c;
  logic [31:0] rdata_b, rdata_c;
  wire  [31:0] ram_data_b, ram_data_c;
  logic [19:0] ram_addr_b, ram_addr_c;
  logic [3:0]  ram_be_n_b, ram_be_n_c;
  logic        ce_b, oe_b, we_b, busy_b;
  logic        ce_c, oe_c, we_c, busy_c;
  logic [59:0] addr3 = {20'h00102, 20'h00101, 20'h00100};

  logic [31:0] mem [256];
  logic        probe_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        s_ce [32];
  logic        s_oe [32];
  logic        s_we [32];
  logic [3:0]  s_ben [32];
  logic [31:0] s_dat [32];
  logic        s_busy [32];

  always #10 clk_50M = ~clk_50M;

  sram_ctrl dut (
    .clk_50M (clk_50M), .reset_n (reset_n),
    .req (req), .we (we), .addr (addr),
    .wdata (wdata), .be (be),
    .ack (ack), .rdata (rdata),
    .ram_data (ram_data), .ram_addr (ram_addr),
    .ram_be_n (ram_be_n), .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n), .ram_we_n (ram_we_n),
    .busy (busy)
  );

  sram_ctrl #(.NUM_PORTS(3), .WAIT_CYCLES(1)) dut_b (
    .clk_50M (clk_50M), .reset_n (reset_n),
    .req (req_b), .we (3'b000), .addr (addr3),
    .wdata (96'h0), .be (12'h0),
    .ack (ack_b), .rdata (rdata_b),
    .ram_data (ram_data_b), .ram_addr (ram_addr_b),
    .ram_be_n (ram_be_n_b), .ram_ce_n (ce_b),
    .ram_oe_n (oe_b), .ram_we_n (we_b),
    .busy (busy_b)
  );

  sram_ctrl #(.NUM_PORTS(3), .WAIT_CYCLES(4)) dut_c (
    .clk_50M (clk_50M), .reset_n (reset_n),
    .req (req_c), .we (3'b000), .addr (addr3),
    .wdata (96'h0), .be (12'h0),
    .ack (ack_c), .rdata (rdata_c),
    .ram_data (ram_data_c), .ram_addr (ram_addr_c),
    .ram_be_n (ram_be_n_c), .ram_ce_n (ce_c),
    .ram_oe_n (oe_c), .ram_we_n (we_c),
    .busy (busy_c)
  );

  // Behavioural SRAM: probe drives 0 only to expose a stray DUT driver.
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] :
                    (probe_en ? 32'h0 : 32'hz);
  assign ram_data_b = (!ce_b && !oe_b) ?
                      ({12'h0, ram_addr_b} ^ 32'hCAFE0000) : 32'hz;
  assign ram_data_c = (!ce_c && !oe_c) ?
                      ({12'h0, ram_addr_c} ^ 32'hCAFE0000) : 32'hz;

  always @(posedge clk_50M) begin
    if (!ram_ce_n && !ram_we_n)
      for (int i = 0; i < 4; i++)
        if (!ram_be_n[i])
          mem[ram_addr[7:0]][i*8 +: 8] <= ram_data[i*8 +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic acc(input int p, input logic w,
                     input logic [19:0] a, input logic [31:0] d,
                     input logic [3:0] b, input bit drop,
                     output int lat);
    we[p] = w;
    addr[p*20 +: 20] = a;
    wdata[p*32 +: 32] = d;
    be[p*4 +: 4] = b;
    req[p] = 1'b1;
    lat = -1;
    for (int n = 1; n < 32; n++) begin
      @(posedge clk_50M); #1;
      s_ce[n] = ram_ce_n;
      s_oe[n] = ram_oe_n;
      s_we[n] = ram_we_n;
      s_ben[n] = ram_be_n;
      s_dat[n] = ram_data;
      s_busy[n] = busy;
      if (drop && n == 1) req[p] = 1'b0;
      if (ack != 2'b00) begin
        lat = n;
        break;
      end
    end
    req[p] = 1'b0;
    chk("ack_port", 64'(ack), 64'(1) << p);
    probe_en = 1'b1;
    #1;
    chk("bus_z_in_done", 64'(ram_data), 64'h0);
    probe_en = 1'b0;
    @(posedge clk_50M); #1;
  endtask

  task automatic sweep(input logic [2:0] r, output int lb, output int lc,
                       output logic [2:0] ab, output logic [2:0] ac);
    lb = -1; lc = -1; ab = '0; ac = '0;
    req_b = r; req_c = r;
    for (int n = 1; n < 32; n++) begin
      @(posedge clk_50M); #1;
      if (ack_b != 3'b000 && lb < 0) begin
        lb = n; ab = ack_b; req_b = '0;
      end
      if (ack_c != 3'b000 && lc < 0) begin
        lc = n; ac = ack_c; req_c = '0;
      end
      if (lb >= 0 && lc >= 0) break;
    end
    req_b = '0; req_c = '0;
    repeat (3) @(posedge clk_50M);
    #1;
  endtask

  initial begin
    int lat, lb, lc, t0, t1;
    logic [2:0] ab, ac;
    logic [1:0] seen;

    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst_pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, busy, ack},
        {3'b111, 4'hF, 1'b0, 2'b00});
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_addr", 64'(ram_addr), 64'h0);
    probe_en = 1'b1;
    #1;
    chk("rst_bus_z", 64'(ram_data), 64'h0);
    probe_en = 1'b0;
    chk("rst_busy_bc", {busy_b, busy_c, ack_b, ack_c}, 8'h00);
    @(negedge clk_50M) reset_n = 1'b1;
    @(posedge clk_50M); #1;

    acc(1, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 1'b0, lat);
    chk("wr_latency", 64'(lat), 64'd4);
    chk("wr_c1", {s_ce[1], s_oe[1], s_we[1], s_ben[1], s_busy[1]},
        {3'b010, 4'h0, 1'b1});
    chk("wr_c2_we", 64'(s_we[2]), 64'h0);
    chk("whold_c3", {s_ce[3], s_oe[3], s_we[3]}, 3'b011);
    chk("whold_data", 64'(s_dat[3]), 64'hDEADBEEF);

    acc(1, 1'b0, 20'h00010, 32'h0, 4'h0, 1'b0, lat);
    chk("rd_latency", 64'(lat), 64'd3);
    chk("rd_c1", {s_ce[1], s_oe[1], s_we[1], s_ben[1]}, {3'b001, 4'h0});
    chk("rd_data", 64'(rdata), 64'hDEADBEEF);

    acc(0, 1'b1, 20'h00010, 32'h0000AB00, 4'b0010, 1'b0, lat);
    chk("bytewr_ben", 64'(s_ben[1]), 64'hD);
    chk("rdata_held", 64'(rdata), 64'hDEADBEEF);

    acc(0, 1'b0, 20'h00010, 32'h0, 4'h0, 1'b1, lat);
    chk("drop_latency", 64'(lat), 64'd3);
    chk("byte_readback", 64'(rdata), 64'hDEADABEF);

    acc(0, 1'b1, 20'h00010, 32'hFFFFFFFF, 4'h0, 1'b0, lat);
    chk("be0_latency", 64'(lat), 64'd4);
    chk("be0_ben", 64'(s_ben[1]), 64'hF);
    acc(1, 1'b0, 20'h00010, 32'h0, 4'h0, 1'b0, lat);
    chk("be0_readback", 64'(rdata), 64'hDEADABEF);

    we[1] = 1'b1;
    addr[20 +: 20] = 20'h00010;
    wdata[32 +: 32] = 32'h55555555;
    be[4 +: 4] = 4'hF;
    req[1] = 1'b1;
    @(posedge clk_50M); #1;
    chk("abort_in_write", 64'(ram_we_n), 64'h0);
    #2;
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("abort_pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n, busy, ack},
        {3'b111, 4'hF, 1'b0, 2'b00});
    chk("abort_rdata", 64'(rdata), 64'h0);
    seen = '0;
    repeat (4) begin
      @(posedge clk_50M); #1;
      seen |= ack;
    end
    chk("abort_no_ack", 64'(seen), 64'h0);
    @(negedge clk_50M) reset_n = 1'b1;
    @(posedge clk_50M); #1;
    chk("abort_idle", 64'(busy), 64'h0);
    acc(0, 1'b0, 20'h00010, 32'h0, 4'h0, 1'b0, lat);
    chk("abort_old_data", 64'(rdata), 64'hDEADABEF);

    we = 2'b10;
    addr = {20'h00020, 20'h00020};
    wdata[32 +: 32] = 32'h12345678;
    be[4 +: 4] = 4'hF;
    req = 2'b11;
    t0 = -1; t1 = -1;
    for (int n = 1; n < 32; n++) begin
      @(posedge clk_50M); #1;
      if (ack[1] && t1 < 0) begin
        t1 = n; req[1] = 1'b0;
      end
      if (ack[0]) begin
        t0 = n; req[0] = 1'b0;
        break;
      end
    end
    req = '0;
    chk("contend_ack1", 64'(t1), 64'd4);
    chk("contend_ack0", 64'(t0), 64'd8);
    chk("contend_rdata", 64'(rdata), 64'h12345678);
    @(posedge clk_50M); #1;

    sweep(3'b001, lb, lc, ab, ac);
    chk("wc1_latency", 64'(lb), 64'd2);
    chk("wc4_latency", 64'(lc), 64'd5);
    chk("wc_p0_ack", {ab, ac}, {3'b001, 3'b001});
    chk("wc1_rdata", 64'(rdata_b), 64'hCAFE0100);
    sweep(3'b111, lb, lc, ab, ac);
    chk("prio_111", {ab, ac}, {3'b100, 3'b100});
    chk("prio_rdata", {rdata_b, rdata_c}, {32'hCAFE0102, 32'hCAFE0102});
    sweep(3'b110, lb, lc, ab, ac);
    chk("prio_110", {ab, ac}, {3'b100, 3'b100});
    sweep(3'b011, lb, lc, ab, ac);
    chk("prio_011", {ab, ac}, {3'b010, 3'b010});
    chk("wc4_p1_rdata", 64'(rdata_c), 64'hCAFE0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
